instruction_fetch: RTL and testbench



---
 rtl/armv8_pkg.sv | 22 ++
 rtl/if_id_register.sv | 50 +++++
 rtl/instruction_fetch.sv | 84 ++++++++
 tb/tb_instruction_fetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/armv8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : armv8_pkg
//  Description : Shared widths, opcodes and constants for the ARMv8 pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package armv8_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    // Primary opcode field [31:26] of the unconditional immediate branch (B)
    localparam logic [5:0] OPC_B = 6'b000101;

    // Instruction word placed in IF/ID when it is flushed
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0;

    // Sequential fetch step, one 32-bit instruction
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

endpackage : armv8_pkg
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_register
//  Description : IF/ID pipeline register. Flush (or reset) inserts a bubble,
//                load captures the fetched instruction, otherwise it holds.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_register
    import armv8_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_predicted,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_valid,
    output logic               o_predicted
);

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_predicted;

    // Flush beats load; with neither asserted the stage is frozen
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pc        <= '0;
            r_instr     <= BUBBLE_INSTR;
            r_valid     <= 1'b0;
            r_predicted <= 1'b0;
        end else if (i_load) begin
            r_pc        <= i_pc;
            r_instr     <= i_instr;
            r_valid     <= 1'b1;
            r_predicted <= i_predicted;
        end
    end

    assign o_pc        = r_pc;
    assign o_instr     = r_instr;
    assign o_valid     = r_valid;
    assign o_predicted = r_predicted;

endmodule : if_id_register
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : IF stage. Owns the PC, drives the instruction memory address
//                and feeds the IF/ID register. Optional B predecode is built
//                when FETCH_B_PREDECODE_EN is defined: an unconditional B seen
//                in IF steers the PC to its target with no bubble.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch
    import armv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  Address,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic [ADDR_W-1:0]  IFID_PC,
    output logic [INSTR_W-1:0] IFID_Instruction,
    output logic               IFID_Valid,
    output logic               IFID_Predicted
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_b_offset;
    logic              w_predecode_hit;

    // Targets are word aligned; low two bits of the request are dropped
    assign w_target = BranchTarget & ~64'h3;

`ifdef FETCH_B_PREDECODE_EN
    // B in IF: imm26 sign-extended and scaled to bytes
    assign w_predecode_hit = (Instruction[31:26] == OPC_B) && !Stall && !Redirect;
    assign w_b_offset      = {{36{Instruction[25]}}, Instruction[25:0], 2'b00};
`else
    assign w_predecode_hit = 1'b0;
    assign w_b_offset      = '0;
`endif

    // Next-PC select: redirect, then stall hold, then predecode, then +4
    always_comb begin
        w_pc_next = r_pc + PC_INC;
        if (Redirect) begin
            w_pc_next = w_target;
        end else if (Stall) begin
            w_pc_next = r_pc;
        end else if (w_predecode_hit) begin
            w_pc_next = r_pc + w_b_offset;
        end
    end

    // Program counter register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign Address = r_pc;

    if_id_register u_if_id (
        .clk         (Clock),
        .rst         (Reset),
        .i_flush     (Redirect),
        .i_load      (!Stall),
        .i_pc        (r_pc),
        .i_instr     (Instruction),
        .i_predicted (w_predecode_hit),
        .o_pc        (IFID_PC),
        .o_instr     (IFID_Instruction),
        .o_valid     (IFID_Valid),
        .o_predicted (IFID_Predicted)
    );

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch: directed scenarios
//                followed by randomized stall/redirect/reset traffic, compared
//                against a behavioural fetch model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

`ifdef FETCH_B_PREDECODE_EN
    localparam bit c_pred = 1'b1;
`else
    localparam bit c_pred = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [63:0] BranchTarget;
    logic [63:0] Address;
    logic [31:0] Instruction;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid;
    logic        IFID_Predicted;

    // Second instance with a non-zero reset vector, free running
    logic [63:0] a38_addr;
    logic [31:0] a38_instr;
    logic [63:0] a38_pc;
    logic [31:0] a38_ifid_instr;
    logic        a38_valid;
    logic        a38_pred;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic [63:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_ifid_valid;
    logic        m_ifid_pred;
    bit          m_known = 1'b0;

    // Team instruction memory: fixed program words, hashed filler elsewhere
    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'h00: imem = 32'hF84003E9;
            64'h04: imem = 32'hF84083EA;
            64'h08: imem = 32'hF84103EB;
            64'h0C: imem = 32'hF84183EC;
            64'h10: imem = 32'hF84203ED;
            64'h28: imem = 32'h17FFFFFD;
            64'h38: imem = 32'h8B1F03E9;
            default: imem = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
        endcase
    endfunction

    assign Instruction = imem(Address);
    assign a38_instr   = imem(a38_addr);

    instruction_fetch #(.RESET_PC(64'h0)) dut (
        .Clock            (clk),
        .Reset            (Reset),
        .Address          (Address),
        .Instruction      (Instruction),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .BranchTarget     (BranchTarget),
        .IFID_PC          (IFID_PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_Valid       (IFID_Valid),
        .IFID_Predicted   (IFID_Predicted)
    );

    instruction_fetch #(.RESET_PC(64'h38)) dut38 (
        .Clock            (clk),
        .Reset            (Reset),
        .Address          (a38_addr),
        .Instruction      (a38_instr),
        .Stall            (1'b0),
        .Redirect         (1'b0),
        .BranchTarget     (64'h0),
        .IFID_PC          (a38_pc),
        .IFID_Instruction (a38_ifid_instr),
        .IFID_Valid       (a38_valid),
        .IFID_Predicted   (a38_pred)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the model by the fetch rules, compare
    task automatic tick(input logic rst_i, input logic st, input logic rd, input logic [63:0] tgt);
        logic [31:0] ins;
        longint      off;
        Reset        = rst_i;
        Stall        = st;
        Redirect     = rd;
        BranchTarget = tgt;
        #1;
        if (m_known) check("Address_pre", Address, m_pc);
        if (rst_i) begin
            m_pc = 64'h0;
            {m_ifid_pc, m_ifid_instr, m_ifid_valid, m_ifid_pred} = '0;
        end else if (rd) begin
            m_pc = {tgt[63:2], 2'b00};
            {m_ifid_pc, m_ifid_instr, m_ifid_valid, m_ifid_pred} = '0;
        end else if (!st) begin
            ins          = imem(m_pc);
            m_ifid_pc    = m_pc;
            m_ifid_instr = ins;
            m_ifid_valid = 1'b1;
            m_ifid_pred  = c_pred && (ins[31:26] == 6'd5);
            if (m_ifid_pred) begin
                off  = $signed(ins[25:0]);
                m_pc = m_pc + 64'(off * 4);
            end else begin
                m_pc = m_pc + 64'd4;
            end
        end
        m_known = 1'b1;
        @(posedge clk);
        #1;
        check("Address",          Address,          m_pc);
        check("IFID_PC",          IFID_PC,          m_ifid_pc);
        check("IFID_Instruction", {32'h0, IFID_Instruction}, {32'h0, m_ifid_instr});
        check("IFID_Valid",       {63'h0, IFID_Valid},       {63'h0, m_ifid_valid});
        check("IFID_Predicted",   {63'h0, IFID_Predicted},   {63'h0, m_ifid_pred});
    endtask

    initial begin
        int r;
        logic [63:0] t;
        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; BranchTarget = '0;
        @(posedge clk); #1;

        // Reset state, including the RESET_PC=0x38 instance
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        check("reset_Address", Address, 64'h0);
        check("reset38_Address", a38_addr, 64'h38);
        check("reset38_valid", {63'h0, a38_valid}, 64'h0);

        // Free run: first capture is RESET_PC instruction on both instances
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        check("first_instr", {32'h0, IFID_Instruction}, 64'hF84003E9);
        check("first38_pc", a38_pc, 64'h38);
        check("first38_instr", {32'h0, a38_ifid_instr}, 64'h8B1F03E9);
        check("first38_valid", {63'h0, a38_valid}, 64'h1);
        tick(1'b0, 1'b0, 1'b0, 64'h0);

        // Stall three cycles at Address 0x8
        check("stall_addr", Address, 64'h8);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 64'h0);
        check("stall_hold_pc", IFID_PC, 64'h4);
        check("stall_hold_instr", {32'h0, IFID_Instruction}, 64'hF84083EA);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        check("stall_release_instr", {32'h0, IFID_Instruction}, 64'hF84103EB);
        repeat (2) tick(1'b0, 1'b0, 1'b0, 64'h0);

        // Redirect together with stall, misaligned low bits ignored
        tick(1'b0, 1'b1, 1'b1, 64'h3B);
        check("redir_bubble", {63'h0, IFID_Valid}, 64'h0);
        check("redir_addr", Address, 64'h38);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        check("redir_target_instr", {32'h0, IFID_Instruction}, 64'h8B1F03E9);

        // B at 0x28
        tick(1'b0, 1'b0, 1'b1, 64'h28);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        check("b_next_addr", Address, c_pred ? 64'h1C : 64'h2C);
        check("b_predicted", {63'h0, IFID_Predicted}, {63'h0, c_pred});

        // Mid-run reset at 0x20 overrides stall and redirect
        tick(1'b0, 1'b0, 1'b1, 64'h20);
        tick(1'b1, 1'b1, 1'b1, 64'h100);
        check("midreset_addr", Address, 64'h0);
        check("midreset_valid", {63'h0, IFID_Valid}, 64'h0);

        // PC wrap
        tick(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        check("wrap_addr", Address, 64'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0: t = {$urandom, $urandom};
                1: t = 64'(($urandom_range(0, 15)) * 4);
                2: t = 64'h28;
                default: t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            endcase
            tick(r < 2, (r % 4) == 1, (r % 9) == 3, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_instruction_fetch
`default_nettype wire
